spmm_scheduler: RTL and testbench
=================================

SPMM_SCHEDULER -- requirements
Module: spmm_scheduler

Interface
REQ-001 SHALL have parameter ROW_CNT_W, default 16, width of the row counters.
REQ-002 SHALL have parameter OCC_W, default 11, width of the WH occupancy counter.
REQ-003 SHALL have parameter HI_THRESH, default 1000, occupancy at which issue stalls; legal only when ≤ 2^OCC_W-1-4.
REQ-004 SHALL have parameter LO_THRESH, default 512, occupancy at or below which issue resumes; legal only when < HI_THRESH.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port start_i  in  1  one-cycle layer start request.
REQ-007 SHALL have port abort_i  in  1  synchronous cancel of the current layer.
REQ-008 SHALL have port total_rows_i  in  ROW_CNT_W  WH words expected; sampled with start_i.
REQ-009 SHALL have port weight_loaded_i  in  1  level; weight BRAMs hold valid data.
REQ-010 SHALL have port spmm_ready_i  in  1  one-cycle pulse per completed WH row (SPMM WH BRAM write).
REQ-011 SHALL have port wh_rd_i  in  1  one-cycle pulse per WH word consumed downstream (DMVM).
REQ-012 SHALL have port spmm_valid_o  out  1  SPMM issue enable.
REQ-013 SHALL have port dmvm_start_o  out  1  one-cycle pulse on the first WH row of a layer.
REQ-014 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-015 SHALL have port done_o  out  1  one-cycle layer-complete pulse.
REQ-016 SHALL have port err_o  out  1  sticky protocol error.
REQ-017 SHALL have port rows_done_o  out  ROW_CNT_W  WH rows written this layer.
REQ-018 SHALL have port occupancy_o  out  OCC_W  WH words written but not yet consumed.

Function
REQ-019 SHALL implement the states IDLE, WAIT_W, RUN, STALL and DONE, held in a state register.
REQ-020 In IDLE, start_i with total_rows_i≠0 SHALL latch total_rows_i, clear rows_done, occupancy and err_o, and go to WAIT_W.
REQ-021 In IDLE, start_i with total_rows_i=0 SHALL go directly to DONE.
REQ-022 In WAIT_W, weight_loaded_i=1 SHALL go to RUN; otherwise the block SHALL stay in WAIT_W indefinitely.
REQ-023 spmm_valid_o SHALL equal (state==RUN), decoded directly from the state register.
REQ-024 The minimum latency from start_i to spmm_valid_o SHALL be 2 cycles.
REQ-025 In RUN or STALL, when rows_done==latched total, the block SHALL go to DONE; this check SHALL take priority over the stall and resume transitions.
REQ-026 In RUN, occupancy ≥ HI_THRESH SHALL go to STALL, so spmm_valid_o falls 1 cycle after the occupancy register reaches the threshold.
REQ-027 In STALL, occupancy ≤ LO_THRESH SHALL go to RUN.
REQ-028 DONE SHALL last exactly 1 cycle, assert done_o during that cycle, then go to IDLE.
REQ-029 Each spmm_ready_i in RUN or STALL SHALL increment rows_done and increment occupancy; rows_done SHALL saturate at the latched total.
REQ-030 Each wh_rd_i SHALL decrement occupancy, in any state.
REQ-031 Simultaneous spmm_ready_i and wh_rd_i SHALL leave occupancy unchanged.
REQ-032 wh_rd_i while occupancy==0 SHALL set err_o and hold occupancy at 0.
REQ-033 Occupancy reaching 2^OCC_W-1 SHALL saturate the counter and set err_o.
REQ-034 spmm_ready_i in IDLE, WAIT_W or DONE, or arriving after rows_done has reached the total, SHALL set err_o and be ignored.
REQ-035 dmvm_start_o SHALL pulse in the cycle after rows_done transitions from 0 to 1; there SHALL be exactly one pulse per layer.
REQ-036 abort_i SHALL go from any state to IDLE on the next edge and clear rows_done and occupancy; it SHALL NOT assert done_o and SHALL NOT clear err_o.
REQ-037 abort_i SHALL take priority over start_i when both are asserted in the same cycle.
REQ-038 start_i outside IDLE SHALL be ignored and SHALL NOT set err_o.
REQ-039 All counters SHALL use unsigned arithmetic with explicit saturation, with no wrap-around.

Reset
REQ-040 Assertion of rst SHALL asynchronously force state=IDLE and drive spmm_valid_o, dmvm_start_o, busy_o, done_o and err_o to 0, and rows_done_o and occupancy_o to 0.
REQ-041 rst asserted mid-layer SHALL discard the latched total; the block SHALL require a new start_i after reset is released.
REQ-042 Release of rst SHALL be synchronous to clk, and the first state transition SHALL occur on the first clk edge after release.

Verification
REQ-043 The bench SHALL cover: start_i with total_rows_i=3, weight_loaded_i=1, then 3 spmm_ready_i pulses -> spmm_valid_o high 2 cycles after start_i, dmvm_start_o exactly once, done_o one cycle, rows_done_o=3, busy_o=0 afterwards.
REQ-044 The bench SHALL cover, with HI_THRESH=4 and LO_THRESH=2: 4 spmm_ready_i pulses with no wh_rd_i -> occupancy_o=4, spmm_valid_o=0 one cycle later; then 2 wh_rd_i -> occupancy_o=2, spmm_valid_o=1 again.
REQ-045 The bench SHALL cover simultaneous spmm_ready_i and wh_rd_i at occupancy_o=1 -> occupancy_o remains 1 and err_o remains 0.
REQ-046 The bench SHALL cover wh_rd_i at occupancy_o=0 -> err_o=1 and occupancy_o=0; err_o stays 1 until the next accepted start_i.
REQ-047 The bench SHALL cover start_i with total_rows_i=0 -> done_o 1 cycle after start_i and spmm_valid_o never asserted.
REQ-048 The bench SHALL cover abort_i in RUN at rows_done_o=5 -> IDLE next cycle, spmm_valid_o=0, rows_done_o=0, done_o never asserted.

Source files
------------

// File: rtl/spmm_scheduler.sv
// Layer sequencer for SPMM row issue and DMVM hand-off, throttling issue on
// the occupancy of the shared WH buffer (stall at HI_THRESH, resume at LO_THRESH).
module spmm_scheduler #(
   parameter int ROW_CNT_W = 16,
   parameter int OCC_W     = 11,
   parameter int HI_THRESH = 1000,
   parameter int LO_THRESH = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [ROW_CNT_W-1:0] total_rows_i,
   input  logic                 weight_loaded_i,
   input  logic                 spmm_ready_i,
   input  logic                 wh_rd_i,
   output logic                 spmm_valid_o,
   output logic                 dmvm_start_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [ROW_CNT_W-1:0] rows_done_o,
   output logic [OCC_W-1:0]     occupancy_o
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_W,
      RUN,
      STALL,
      DONE
   } state_t;

   localparam logic [OCC_W-1:0] OCC_HI  = OCC_W'(HI_THRESH);
   localparam logic [OCC_W-1:0] OCC_LO  = OCC_W'(LO_THRESH);
   localparam logic [OCC_W-1:0] OCC_MAX = '1;

   state_t               state;
   logic [ROW_CNT_W-1:0] total_rows;
   logic [ROW_CNT_W-1:0] rows_done;
   logic [OCC_W-1:0]     occupancy;
   logic                 row_accept;
   logic                 start_layer;

   // A row is only accepted while issuing and before the layer total is reached.
   always_comb begin
      row_accept  = spmm_ready_i && ((state == RUN) || (state == STALL)) &&
                    (rows_done < total_rows);
      start_layer = (state == IDLE) && start_i && (total_rows_i != '0);
   end

   assign spmm_valid_o = (state == RUN);
   assign busy_o       = (state != IDLE);
   assign done_o       = (state == DONE);
   assign rows_done_o  = rows_done;
   assign occupancy_o  = occupancy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         total_rows   <= '0;
         rows_done    <= '0;
         occupancy    <= '0;
         err_o        <= 1'b0;
         dmvm_start_o <= 1'b0;
      end else begin
         dmvm_start_o <= 1'b0;
         if (abort_i) begin
            state     <= IDLE;
            rows_done <= '0;
            occupancy <= '0;
         end else if (start_layer) begin
            state      <= WAIT_W;
            total_rows <= total_rows_i;
            rows_done  <= '0;
            occupancy  <= '0;
            err_o      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) state <= DONE;
               end
               WAIT_W: begin
                  if (weight_loaded_i) state <= RUN;
               end
               RUN: begin
                  if (rows_done == total_rows) state <= DONE;
                  else if (occupancy >= OCC_HI) state <= STALL;
               end
               STALL: begin
                  if (rows_done == total_rows) state <= DONE;
                  else if (occupancy <= OCC_LO) state <= RUN;
               end
               default: state <= IDLE;
            endcase

            if (row_accept) begin
               rows_done <= rows_done + ROW_CNT_W'(1);
               if (rows_done == '0) dmvm_start_o <= 1'b1;
            end else if (spmm_ready_i) begin
               err_o <= 1'b1;
            end

            // A write and a read in the same cycle cancel out.
            if (row_accept && !wh_rd_i) begin
               if (occupancy >= OCC_MAX - OCC_W'(1)) begin
                  occupancy <= OCC_MAX;
                  err_o     <= 1'b1;
               end else begin
                  occupancy <= occupancy + OCC_W'(1);
               end
            end else if (wh_rd_i && !row_accept) begin
               if (occupancy == '0) err_o <= 1'b1;
               else occupancy <= occupancy - OCC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_spmm_scheduler.sv
// Self-checking bench for spmm_scheduler: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_spmm_scheduler;

   localparam int RW      = 8;
   localparam int OW      = 4;
   localparam int HI      = 4;
   localparam int LO      = 2;
   localparam int OCC_MAX = (1 << OW) - 1;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_RUN   = 2;
   localparam int P_STALL = 3;
   localparam int P_DONE  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [RW-1:0] total_rows_i = '0;
   logic          weight_loaded_i = 1'b0;
   logic          spmm_ready_i = 1'b0;
   logic          wh_rd_i = 1'b0;
   logic          spmm_valid_o, dmvm_start_o, busy_o, done_o, err_o;
   logic [RW-1:0] rows_done_o;
   logic [OW-1:0] occupancy_o;

   int errors = 0;
   int checks = 0;

   int m_phase, m_total, m_rows, m_occ;
   bit m_err, m_dmvm;

   spmm_scheduler #(
      .ROW_CNT_W(RW),
      .OCC_W    (OW),
      .HI_THRESH(HI),
      .LO_THRESH(LO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .total_rows_i   (total_rows_i),
      .weight_loaded_i(weight_loaded_i),
      .spmm_ready_i   (spmm_ready_i),
      .wh_rd_i        (wh_rd_i),
      .spmm_valid_o   (spmm_valid_o),
      .dmvm_start_o   (dmvm_start_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o),
      .rows_done_o    (rows_done_o),
      .occupancy_o    (occupancy_o)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      m_phase = P_IDLE;
      m_total = 0;
      m_rows  = 0;
      m_occ   = 0;
      m_err   = 1'b0;
      m_dmvm  = 1'b0;
   endtask

   // Advances the model by one clock using the inputs currently applied.
   task automatic model_step();
      int up;
      int nphase;
      int nocc;
      m_dmvm = 1'b0;
      if (rst) return;
      if (abort_i) begin
         m_phase = P_IDLE;
         m_rows  = 0;
         m_occ   = 0;
         return;
      end
      if (m_phase == P_IDLE && start_i && total_rows_i != 0) begin
         m_phase = P_WAIT;
         m_total = int'(total_rows_i);
         m_rows  = 0;
         m_occ   = 0;
         m_err   = 1'b0;
         return;
      end
      up = (spmm_ready_i && (m_phase == P_RUN || m_phase == P_STALL) && m_rows < m_total) ? 1 : 0;
      if (spmm_ready_i && up == 0) m_err = 1'b1;
      nphase = m_phase;
      case (m_phase)
         P_IDLE:  if (start_i) nphase = P_DONE;
         P_WAIT:  if (weight_loaded_i) nphase = P_RUN;
         P_RUN:   if (m_rows == m_total) nphase = P_DONE; else if (m_occ >= HI) nphase = P_STALL;
         P_STALL: if (m_rows == m_total) nphase = P_DONE; else if (m_occ <= LO) nphase = P_RUN;
         default: nphase = P_IDLE;
      endcase
      if (up == 1) begin
         if (m_rows == 0) m_dmvm = 1'b1;
         m_rows++;
      end
      nocc = m_occ + up - int'(wh_rd_i);
      if (nocc < 0) begin
         nocc  = 0;
         m_err = 1'b1;
      end else if (nocc >= OCC_MAX && nocc > m_occ) begin
         nocc  = OCC_MAX;
         m_err = 1'b1;
      end
      m_occ   = nocc;
      m_phase = nphase;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      m_reset();
      tick();
      tick();
      checks++;
      if ({spmm_valid_o, dmvm_start_o, busy_o, done_o, err_o, rows_done_o, occupancy_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%0b dmvm=%0b busy=%0b done=%0b err=%0b rows=%0d occ=%0d, expected all 0",
                  spmm_valid_o, dmvm_start_o, busy_o, done_o, err_o, rows_done_o, occupancy_o);
      end
      #2 rst = 1'b0;
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy got %0b expected 0", busy_o);
      end
   endtask

   task automatic test_basic();
      int dmvm_cnt = 0;
      weight_loaded_i = 1'b1;
      start_i = 1'b1;
      total_rows_i = 8'd3;
      tick();
      start_i = 1'b0;
      checks++;
      if (spmm_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_wait: valid=%0b busy=%0b, expected valid=0 busy=1", spmm_valid_o, busy_o);
      end
      tick();
      checks++;
      if (spmm_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency: valid got %0b expected 1 two cycles after start", spmm_valid_o);
      end
      for (int unsigned i = 0; i < 3; i++) begin
         spmm_ready_i = 1'b1;
         tick();
         spmm_ready_i = 1'b0;
         if (dmvm_start_o) dmvm_cnt++;
         checks++;
         if (rows_done_o !== RW'(i + 1) || dmvm_start_o !== (i == 0)) begin
            errors++;
            $display("FAIL basic_row%0d: rows=%0d dmvm=%0b, expected rows=%0d dmvm=%0b",
                     i, rows_done_o, dmvm_start_o, i + 1, (i == 0));
         end
      end
      tick();
      if (dmvm_start_o) dmvm_cnt++;
      checks++;
      if (done_o !== 1'b1 || spmm_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done=%0b valid=%0b, expected done=1 valid=0", done_o, spmm_valid_o);
      end
      tick();
      if (dmvm_start_o) dmvm_cnt++;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || rows_done_o !== 8'd3 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_after: done=%0b busy=%0b rows=%0d err=%0b, expected 0 0 3 0",
                  done_o, busy_o, rows_done_o, err_o);
      end
      checks++;
      if (dmvm_cnt != 1) begin
         errors++;
         $display("FAIL basic_dmvm_count: got %0d pulses expected 1", dmvm_cnt);
      end
   endtask

   task automatic test_stall();
      start_i = 1'b1;
      total_rows_i = 8'd10;
      tick();
      start_i = 1'b0;
      tick();
      for (int unsigned i = 0; i < 4; i++) begin
         spmm_ready_i = 1'b1;
         tick();
      end
      spmm_ready_i = 1'b0;
      checks++;
      if (occupancy_o !== 4'd4 || spmm_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL stall_reach: occ=%0d valid=%0b, expected occ=4 valid=1", occupancy_o, spmm_valid_o);
      end
      tick();
      checks++;
      if (spmm_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_enter: valid got %0b expected 0", spmm_valid_o);
      end
      wh_rd_i = 1'b1;
      tick();
      tick();
      wh_rd_i = 1'b0;
      checks++;
      if (occupancy_o !== 4'd2 || spmm_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_drain: occ=%0d valid=%0b, expected occ=2 valid=0", occupancy_o, spmm_valid_o);
      end
      tick();
      checks++;
      if (spmm_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL stall_resume: valid got %0b expected 1", spmm_valid_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
   endtask

   task automatic test_simul_and_underflow();
      start_i = 1'b1;
      total_rows_i = 8'd10;
      tick();
      start_i = 1'b0;
      tick();
      spmm_ready_i = 1'b1;
      tick();
      wh_rd_i = 1'b1;
      tick();
      spmm_ready_i = 1'b0;
      checks++;
      if (occupancy_o !== 4'd1 || err_o !== 1'b0 || rows_done_o !== 8'd2) begin
         errors++;
         $display("FAIL simul_rw: occ=%0d err=%0b rows=%0d, expected occ=1 err=0 rows=2",
                  occupancy_o, err_o, rows_done_o);
      end
      tick();
      tick();
      wh_rd_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || occupancy_o !== 4'd0) begin
         errors++;
         $display("FAIL underflow: err=%0b occ=%0d, expected err=1 occ=0", err_o, occupancy_o);
      end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b1 || rows_done_o !== 8'd2) begin
         errors++;
         $display("FAIL start_ignored: err=%0b busy=%0b rows=%0d, expected 1 1 2", err_o, busy_o, rows_done_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_keeps_err: err=%0b busy=%0b, expected err=1 busy=0", err_o, busy_o);
      end
      start_i = 1'b1;
      total_rows_i = 8'd2;
      tick();
      start_i = 1'b0;
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL start_clears_err: err got %0b expected 0", err_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
   endtask

   task automatic test_zero_rows();
      int valid_seen = 0;
      start_i = 1'b1;
      total_rows_i = 8'd0;
      tick();
      start_i = 1'b0;
      if (spmm_valid_o) valid_seen++;
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: done got %0b expected 1", done_o);
      end
      tick();
      if (spmm_valid_o) valid_seen++;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_seen != 0) begin
         errors++;
         $display("FAIL zero_after: done=%0b busy=%0b valid_seen=%0d, expected 0 0 0", done_o, busy_o, valid_seen);
      end
   endtask

   task automatic test_abort();
      int done_seen = 0;
      start_i = 1'b1;
      total_rows_i = 8'd20;
      tick();
      start_i = 1'b0;
      tick();
      spmm_ready_i = 1'b1;
      tick();
      wh_rd_i = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         tick();
         if (done_o) done_seen++;
      end
      spmm_ready_i = 1'b0;
      wh_rd_i = 1'b0;
      checks++;
      if (rows_done_o !== 8'd5 || spmm_valid_o !== 1'b1 || occupancy_o !== 4'd1) begin
         errors++;
         $display("FAIL abort_pre: rows=%0d valid=%0b occ=%0d, expected 5 1 1", rows_done_o, spmm_valid_o, occupancy_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      if (done_o) done_seen++;
      checks++;
      if (busy_o !== 1'b0 || spmm_valid_o !== 1'b0 || rows_done_o !== 8'd0 || occupancy_o !== 4'd0) begin
         errors++;
         $display("FAIL abort_idle: busy=%0b valid=%0b rows=%0d occ=%0d, expected all 0",
                  busy_o, spmm_valid_o, rows_done_o, occupancy_o);
      end
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         if (done_o) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL abort_no_done: done seen %0d times expected 0", done_seen);
      end
   endtask

   task automatic test_saturate();
      start_i = 1'b1;
      total_rows_i = 8'd30;
      tick();
      start_i = 1'b0;
      tick();
      spmm_ready_i = 1'b1;
      for (int unsigned i = 1; i <= 16; i++) begin
         tick();
         if (i == 14) begin
            checks++;
            if (occupancy_o !== 4'd14 || err_o !== 1'b0) begin
               errors++;
               $display("FAIL sat_below: occ=%0d err=%0b, expected 14 0", occupancy_o, err_o);
            end
         end
         if (i == 15) begin
            checks++;
            if (occupancy_o !== 4'd15 || err_o !== 1'b1) begin
               errors++;
               $display("FAIL sat_reach: occ=%0d err=%0b, expected 15 1", occupancy_o, err_o);
            end
         end
      end
      spmm_ready_i = 1'b0;
      checks++;
      if (occupancy_o !== 4'd15 || rows_done_o !== 8'd16) begin
         errors++;
         $display("FAIL sat_hold: occ=%0d rows=%0d, expected 15 16", occupancy_o, rows_done_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
   endtask

   task automatic test_late_ready();
      spmm_ready_i = 1'b1;
      tick();
      spmm_ready_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || rows_done_o !== 8'd0) begin
         errors++;
         $display("FAIL ready_idle: err=%0b rows=%0d, expected err=1 rows=0", err_o, rows_done_o);
      end
      start_i = 1'b1;
      total_rows_i = 8'd1;
      tick();
      start_i = 1'b0;
      tick();
      spmm_ready_i = 1'b1;
      tick();
      tick();
      spmm_ready_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || rows_done_o !== 8'd1 || done_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_late: err=%0b rows=%0d done=%0b, expected 1 1 1", err_o, rows_done_o, done_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      start_i = 1'b1;
      total_rows_i = 8'd5;
      tick();
      start_i = 1'b0;
      tick();
      spmm_ready_i = 1'b1;
      tick();
      spmm_ready_i = 1'b0;
      #2 rst = 1'b1;
      m_reset();
      #1;
      checks++;
      if ({spmm_valid_o, dmvm_start_o, busy_o, done_o, err_o, rows_done_o, occupancy_o} !== '0) begin
         errors++;
         $display("FAIL reset_async: got valid=%0b busy=%0b rows=%0d occ=%0d, expected all 0",
                  spmm_valid_o, busy_o, rows_done_o, occupancy_o);
      end
      tick();
      #2 rst = 1'b0;
      tick();
      tick();
      checks++;
      if (busy_o !== 1'b0 || spmm_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_needs_start: busy=%0b valid=%0b, expected 0 0", busy_o, spmm_valid_o);
      end
      start_i = 1'b1;
      total_rows_i = 8'd1;
      tick();
      start_i = 1'b0;
      tick();
      checks++;
      if (spmm_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_restart: valid got %0b expected 1", spmm_valid_o);
      end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
   endtask

   task automatic test_random();
      logic [16:0] act, exp;
      for (int unsigned cyc = 0; cyc < 400; cyc++) begin
         start_i      = ($urandom_range(0, 11) == 0);
         total_rows_i = RW'($urandom_range(0, 12));
         abort_i      = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) weight_loaded_i = ~weight_loaded_i;
         spmm_ready_i = ($urandom_range(0, 1) == 1);
         wh_rd_i      = ($urandom_range(0, 2) == 0);
         tick();
         act = {spmm_valid_o, dmvm_start_o, busy_o, done_o, err_o, rows_done_o, occupancy_o};
         exp = {m_phase == P_RUN, m_dmvm, m_phase != P_IDLE, m_phase == P_DONE, m_err,
                RW'(m_rows), OW'(m_occ)};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL random_cyc%0d: {valid,dmvm,busy,done,err,rows,occ} got %h expected %h", cyc, act, exp);
         end
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      spmm_ready_i = 1'b0;
      wh_rd_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_simul_and_underflow();
      test_zero_rows();
      test_abort();
      test_saturate();
      test_late_ready();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
